store_merge_buffer: RTL and testbench
=====================================

// Module: store_merge_buffer
// PURPOSE
// Parametrised successor to the EXE-stage byte-write-enable logic. Takes committed stores from MEM,
// generates byte strobes and lane-aligned data for a DW-bit data path, flags misaligned stores,
// and holds stores in a DEPTH-entry FIFO with tail write-merging. Drains to the DCache via valid/ready.
// Reports load/store address hazards so younger loads can stall.
// PARAMETERS
// DW     32  data-path width in bits; 32 or 64. OFFW = $clog2(DW/8).
// DEPTH  4   FIFO entries; power of two, >= 2.
// AW     32  physical address width.
// PORTS
// clk          in   1      rising-edge clock
// resetn       in   1      asynchronous, active-low reset
// enq_valid    in   1      store request from MEM
// enq_kill     in   1      same-cycle exception/flush; suppresses the enqueue
// enq_addr     in   AW     byte address
// enq_size     in   2      SB=00 SH=01 SW=10 SD=11 (SD legal only when DW=64)
// enq_data     in   DW     store value, right-aligned (rt)
// enq_ready    out  1      buffer can accept (allocate or merge) this cycle
// exc_addr_err out  1      misaligned/illegal store; combinational, qualified by enq_valid
// deq_valid    out  1      head entry valid
// deq_ready    in   1      DCache accepts head
// deq_addr     out  AW     head address, DW-aligned (low OFFW bits zero)
// deq_data     out  DW     head data, lanes placed by offset
// deq_wstrb    out  DW/8   head byte strobes
// ld_valid     in   1      load probe valid
// ld_addr      in   AW     load byte address
// ld_hazard    out  1      probe matches a buffered DW-aligned address
// empty, full  out  1      occupancy status
// BEHAVIOUR
// - Reset (async, resetn=0): all valid bits, head/tail pointers and count cleared. deq_valid=0,
//   empty=1, full=0. Reset mid-drain drops every entry; no partial write is retried.
// - Strobe: base mask SB=1, SH=2'b11, SW=4'hF, SD=8'hFF (LSB-aligned). wstrb = base << addr[OFFW-1:0].
//   Data: enq_data << (8*addr[OFFW-1:0]); bytes outside the strobe are don't-care.
// - exc_addr_err = enq_valid & (SH&addr[0] | SW&addr[1:0]!=0 | SD&addr[2:0]!=0 | SD&DW==32).
// - Accept: fire = enq_valid & enq_ready & ~enq_kill & ~exc_addr_err. Errored or killed stores
//   never touch state.
// - Merge: when the tail-most valid entry has an equal DW-aligned address and is not being dequeued
//   this cycle, the entry merges the store: strobes OR, and newly strobed bytes overwrite.
//   Otherwise the store allocates a new entry at tail.
// - enq_ready = merge_possible | ~full | (deq_valid & deq_ready). Full plus merge-able is accepted.
// - Dequeue: deq_fire = deq_valid & deq_ready. Head advances next cycle. Outputs are registered
//   straight from the head entry (no combinational path from enq). 0-cycle latency from
//   enqueue into an empty buffer is forbidden: deq_valid rises the cycle after fire.
// - Simultaneous deq_fire and allocate: count unchanged, both pointers advance, wrap mod DEPTH.
//   Simultaneous deq_fire and merge into a single-entry buffer: merge suppressed, store allocates.
// - ld_hazard = ld_valid & OR over valid entries of (entry_addr == ld_addr & ~(DW/8-1)).
//   Combinational, and includes the entry currently leaving. Entry written this cycle is not visible.
// - count is $clog2(DEPTH)+1 bits. full = (count==DEPTH), empty = (count==0), both registered.
// - Stores drain strictly in order. Merging never reorders, because only the tail is merge-able.
// STRUCTURE
// - Shared package (cpu_defines): typedef store_size_t {SB,SH,SW,SD}; typedef sb_entry_t
//   {valid, addr, data, wstrb}; localparam OFFW.
// - Sub-module store_lane_align (combinational): size/addr/data -> wstrb, shifted data, addr_err.
//   Instantiated once. The FIFO, merge logic and hazard CAM live in the top.
// TESTING
// 1. DW=32, SB addr 0x103 data 0xAB -> one entry; deq_addr 0x100, wstrb 4'b1000, data[31:24]=0xAB.
// 2. SH addr 0x202 -> exc_addr_err=0, wstrb 4'b1100. SW addr 0x206 -> exc_addr_err=1, count unchanged.
// 3. deq_ready=0. SB 0x300 (0x11), then SB 0x301 (0x22) -> single entry, wstrb 4'b0011, data[15:0]=0x2211.
// 4. Fill DEPTH=4 with distinct addresses -> full=1, enq_ready=0 for a new address, enq_ready=1 for the
//    tail's address. Deq+enq in the same cycle -> count stays 4 and pointers wrap.
// 5. DW=64, SD addr 0x408 -> wstrb 8'hFF. SD addr 0x404 -> error. DW=32 SD -> error.
// 6. ld_addr 0x101 with buffered 0x100 entry -> ld_hazard=1. Assert resetn=0 mid-drain ->
//    deq_valid=0 and empty=1 immediately. enq_kill=1 -> no state change.

Source files
------------

// File: rtl/store_merge_buffer_pkg.sv
// -----------------------------------------------------------------------------
// store_merge_buffer_pkg
// Purpose : shared types and helpers for the store merge buffer slice.
//           Defines the store-size encoding, the size -> base byte mask
//           helper and the lane-offset width helper.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package store_merge_buffer_pkg;

    // Store size encoding as it arrives from the MEM stage.
    typedef enum logic [1:0] {
        SB = 2'b00,
        SH = 2'b01,
        SW = 2'b10,
        SD = 2'b11
    } store_size_t;

    // Widest data path the buffer supports, in bytes.
    localparam int MAX_STRB = 8;

    // LSB-aligned byte mask covering the bytes a store of this size touches.
    function automatic logic [MAX_STRB-1:0] sizeBaseMask(input store_size_t size);
        case (size)
            SB:      return 8'h01;
            SH:      return 8'h03;
            SW:      return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    // Number of address bits that select a byte lane within a DW-bit word.
    function automatic int offsetWidth(input int dw);
        return $clog2(dw / 8);
    endfunction

endpackage

// File: rtl/store_merge_buffer_lane_align.sv
// -----------------------------------------------------------------------------
// store_merge_buffer_lane_align
// Purpose : combinational lane alignment of a right-aligned store value.
//           Produces byte strobes, lane-shifted data and a misalignment flag.
// Ports   : size_i     store size (SB/SH/SW/SD)
//           addrLow_i  low three bits of the byte address
//           data_i     right-aligned store value
//           wstrb_o    byte strobes, base mask shifted by the lane offset
//           data_o     store value shifted onto its byte lanes
//           addrErr_o  misaligned store, or SD on a 32-bit data path
// -----------------------------------------------------------------------------
module store_merge_buffer_lane_align
    import store_merge_buffer_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [1:0]      size_i,
    input  logic [2:0]      addrLow_i,
    input  logic [DW-1:0]   data_i,
    output logic [DW/8-1:0] wstrb_o,
    output logic [DW-1:0]   data_o,
    output logic            addrErr_o
);

    localparam int STRB = DW / 8;
    localparam int OFFW = offsetWidth(DW);

    store_size_t           sizeE;
    logic [MAX_STRB-1:0]   baseMask;
    logic [OFFW-1:0]       laneOffset;
    logic [OFFW+2:0]       shiftBits;

    // Strobe and data both move by the byte offset inside the data word;
    // the data shift is the same offset counted in bits.
    always_comb begin
        sizeE      = store_size_t'(size_i);
        baseMask   = sizeBaseMask(sizeE);
        laneOffset = addrLow_i[OFFW-1:0];
        shiftBits  = {laneOffset, 3'b000};
        wstrb_o    = STRB'(baseMask) << laneOffset;
        data_o     = data_i << shiftBits;
        // A doubleword cannot exist on a 32-bit path even when aligned.
        case (sizeE)
            SB:      addrErr_o = 1'b0;
            SH:      addrErr_o = addrLow_i[0];
            SW:      addrErr_o = |addrLow_i[1:0];
            default: addrErr_o = (|addrLow_i) | (DW == 32);
        endcase
    end

endmodule

// File: rtl/store_merge_buffer.sv
// -----------------------------------------------------------------------------
// store_merge_buffer
// Purpose : in-order store buffer between MEM and the DCache. Stores are lane
//           aligned, checked for misalignment and queued in a DEPTH-entry
//           FIFO; a store to the same DW-aligned word as the tail entry is
//           merged into it. Loads probe the buffer for address hazards.
// Ports   : clk, resetn             clock, async active-low reset
//           enq_valid/kill/addr/size/data, enq_ready   store request from MEM
//           exc_addr_err           misaligned/illegal store (combinational)
//           deq_valid/ready/addr/data/wstrb            head entry to DCache
//           ld_valid, ld_addr, ld_hazard               load hazard probe
//           empty, full            registered occupancy status
// -----------------------------------------------------------------------------
module store_merge_buffer
    import store_merge_buffer_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            enq_valid,
    input  logic            enq_kill,
    input  logic [AW-1:0]   enq_addr,
    input  logic [1:0]      enq_size,
    input  logic [DW-1:0]   enq_data,
    output logic            enq_ready,
    output logic            exc_addr_err,
    output logic            deq_valid,
    input  logic            deq_ready,
    output logic [AW-1:0]   deq_addr,
    output logic [DW-1:0]   deq_data,
    output logic [DW/8-1:0] deq_wstrb,
    input  logic            ld_valid,
    input  logic [AW-1:0]   ld_addr,
    output logic            ld_hazard,
    output logic            empty,
    output logic            full
);

    localparam int STRB = DW / 8;
    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;
    localparam logic [AW-1:0] ALIGN_MASK = ~AW'(STRB - 1);

    typedef struct packed {
        logic            valid;
        logic [AW-1:0]   addr;
        logic [DW-1:0]   data;
        logic [STRB-1:0] wstrb;
    } sb_entry_t;

    sb_entry_t       entryQ [DEPTH];
    sb_entry_t       entryD [DEPTH];
    logic [PW-1:0]   headQ, headD, tailQ, tailD, tailIdx;
    logic [CW-1:0]   countQ, countD;
    logic            fullQ, emptyQ;

    logic [STRB-1:0] alignStrb;
    logic [DW-1:0]   alignData;
    logic            alignErr;
    logic [AW-1:0]   enqWordAddr, ldWordAddr;
    logic            deqFire, mergePossible, enqFire, doMerge, doAlloc, hazardHit;

    store_merge_buffer_lane_align #(.DW(DW)) u_lane_align (
        .size_i    (enq_size),
        .addrLow_i (enq_addr[2:0]),
        .data_i    (enq_data),
        .wstrb_o   (alignStrb),
        .data_o    (alignData),
        .addrErr_o (alignErr)
    );

    assign enqWordAddr = enq_addr & ALIGN_MASK;
    assign ldWordAddr  = ld_addr & ALIGN_MASK;
    assign tailIdx     = tailQ - PW'(1);

    assign deq_valid = entryQ[headQ].valid;
    assign deq_addr  = entryQ[headQ].addr;
    assign deq_data  = entryQ[headQ].data;
    assign deq_wstrb = entryQ[headQ].wstrb;
    assign deqFire   = deq_valid & deq_ready;

    // Only the newest entry may absorb a store, which keeps drain order intact.
    // If that entry is also the one leaving this cycle the store must allocate.
    assign mergePossible = entryQ[tailIdx].valid
                         & (entryQ[tailIdx].addr == enqWordAddr)
                         & ~(deqFire & (countQ == CW'(1)));

    assign enq_ready    = mergePossible | ~fullQ | deqFire;
    assign exc_addr_err = enq_valid & alignErr;
    assign enqFire      = enq_valid & enq_ready & ~enq_kill & ~alignErr;
    assign doMerge      = enqFire & mergePossible;
    assign doAlloc      = enqFire & ~mergePossible;

    // Next FIFO state: retire the head, then merge into or append at the tail.
    // When full, an allocate lands on the slot the head vacates this cycle.
    always_comb begin
        entryD = entryQ;
        headD  = headQ;
        tailD  = tailQ;
        if (deqFire) begin
            entryD[headQ].valid = 1'b0;
            headD               = headQ + PW'(1);
        end
        if (doMerge) begin
            entryD[tailIdx].wstrb = entryQ[tailIdx].wstrb | alignStrb;
            for (int b = 0; b < STRB; b++) begin
                if (alignStrb[b]) begin
                    entryD[tailIdx].data[8*b +: 8] = alignData[8*b +: 8];
                end
            end
        end
        if (doAlloc) begin
            entryD[tailQ].valid = 1'b1;
            entryD[tailQ].addr  = enqWordAddr;
            entryD[tailQ].data  = alignData;
            entryD[tailQ].wstrb = alignStrb;
            tailD               = tailQ + PW'(1);
        end
        countD = countQ + CW'(doAlloc) - CW'(deqFire);
    end

    // The hazard CAM looks at registered entries only, so a store written
    // this cycle is invisible while the entry draining this cycle still hits.
    always_comb begin
        hazardHit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entryQ[i].valid && (entryQ[i].addr == ldWordAddr)) begin
                hazardHit = 1'b1;
            end
        end
    end
    assign ld_hazard = ld_valid & hazardHit;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                entryQ[i] <= '0;
            end
            headQ  <= '0;
            tailQ  <= '0;
            countQ <= '0;
            fullQ  <= 1'b0;
            emptyQ <= 1'b1;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entryQ[i] <= entryD[i];
            end
            headQ  <= headD;
            tailQ  <= tailD;
            countQ <= countD;
            fullQ  <= (countD == CW'(DEPTH));
            emptyQ <= (countD == '0);
        end
    end

    assign full  = fullQ;
    assign empty = emptyQ;

endmodule

// File: tb/tb_store_merge_buffer.sv
// -----------------------------------------------------------------------------
// tb_store_merge_buffer
// Purpose : self-checking bench for store_merge_buffer. A 32-bit instance
//           takes a vector table, hand-written corner sequences and a random
//           run checked against a queue model; a 64-bit instance covers
//           doubleword stores.
// -----------------------------------------------------------------------------
module tb_store_merge_buffer;

    logic clk = 1'b0;
    logic resetn;

    // Clock with period 10; inputs change just after rising edges and
    // outputs are sampled on falling edges.
    always #5 clk = ~clk;

    logic        enqValid, enqKill, enqReady, excErr;
    logic [31:0] enqAddr, enqData;
    logic [1:0]  enqSize;
    logic        deqValid, deqReady;
    logic [31:0] deqAddr, deqData;
    logic [3:0]  deqWstrb;
    logic        ldValid, ldHazard, emptyS, fullS;
    logic [31:0] ldAddr;

    logic        wEnqValid, wEnqKill, wEnqReady, wExcErr;
    logic [31:0] wEnqAddr;
    logic [1:0]  wEnqSize;
    logic [63:0] wEnqData;
    logic        wDeqValid, wDeqReady;
    logic [31:0] wDeqAddr;
    logic [63:0] wDeqData;
    logic [7:0]  wDeqWstrb;
    logic        wLdValid, wLdHazard, wEmpty, wFull;
    logic [31:0] wLdAddr;

    int vecCount  = 0;
    int missCount = 0;

    store_merge_buffer #(.DW(32), .DEPTH(4), .AW(32)) dut32 (
        .clk(clk), .resetn(resetn),
        .enq_valid(enqValid), .enq_kill(enqKill), .enq_addr(enqAddr),
        .enq_size(enqSize), .enq_data(enqData), .enq_ready(enqReady),
        .exc_addr_err(excErr),
        .deq_valid(deqValid), .deq_ready(deqReady), .deq_addr(deqAddr),
        .deq_data(deqData), .deq_wstrb(deqWstrb),
        .ld_valid(ldValid), .ld_addr(ldAddr), .ld_hazard(ldHazard),
        .empty(emptyS), .full(fullS)
    );

    store_merge_buffer #(.DW(64), .DEPTH(4), .AW(32)) dut64 (
        .clk(clk), .resetn(resetn),
        .enq_valid(wEnqValid), .enq_kill(wEnqKill), .enq_addr(wEnqAddr),
        .enq_size(wEnqSize), .enq_data(wEnqData), .enq_ready(wEnqReady),
        .exc_addr_err(wExcErr),
        .deq_valid(wDeqValid), .deq_ready(wDeqReady), .deq_addr(wDeqAddr),
        .deq_data(wDeqData), .deq_wstrb(wDeqWstrb),
        .ld_valid(wLdValid), .ld_addr(wLdAddr), .ld_hazard(wLdHazard),
        .empty(wEmpty), .full(wFull)
    );

    // One table row: a single store into an empty 32-bit buffer and what
    // the head entry must look like afterwards.
    typedef struct {
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] data;
        logic        expErr;
        logic [31:0] expAddr;
        logic [3:0]  expStrb;
        logic [31:0] expData;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs [NVEC];

    // Reference model entry: one buffered DW-aligned word.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } model_t;

    model_t q [$];

    // Compare one value and record the outcome.
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drive the 32-bit instance's store and drain inputs.
    task automatic applyStimulus(input logic v, input logic kill, input logic [1:0] size,
                                 input logic [31:0] addr, input logic [31:0] data, input logic dr);
        enqValid = v;
        enqKill  = kill;
        enqSize  = size;
        enqAddr  = addr;
        enqData  = data;
        deqReady = dr;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] laneMask32(input logic [3:0] s);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{s[b]}};
        return m;
    endfunction

    // Alignment rules restated: a store must start on a multiple of its size,
    // and a doubleword needs a 64-bit path.
    function automatic logic modelErr(input logic [1:0] size, input logic [31:0] addr, input int dw);
        int bytes;
        bytes = 1 << size;
        if (size == 2'd3 && dw == 32) return 1'b1;
        return (addr % bytes) != 0;
    endfunction

    // Bounded run time: anything hanging this long is a failure.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [1:0]  rSize;
        logic [31:0] rAddr, rData, word, stData, tmpD;
        logic        rV, rKill, rDr, expValid, deqF, mergeOk, expReady, expErr, hz, fire;
        logic [3:0]  stStrb;
        int          off, strbInt;
        model_t      tmp;

        vecs[0] = '{2'd0, 32'h103, 32'h0000_00AB, 1'b0, 32'h100, 4'b1000, 32'hAB00_0000};
        vecs[1] = '{2'd1, 32'h202, 32'h0000_1234, 1'b0, 32'h200, 4'b1100, 32'h1234_0000};
        vecs[2] = '{2'd2, 32'h206, 32'h1122_3344, 1'b1, 32'h0,   4'b0000, 32'h0};
        vecs[3] = '{2'd2, 32'h204, 32'hDEAD_BEEF, 1'b0, 32'h204, 4'b1111, 32'hDEAD_BEEF};
        vecs[4] = '{2'd1, 32'h201, 32'h0000_5555, 1'b1, 32'h0,   4'b0000, 32'h0};
        vecs[5] = '{2'd3, 32'h408, 32'h0000_0000, 1'b1, 32'h0,   4'b0000, 32'h0};
        vecs[6] = '{2'd0, 32'h101, 32'h0000_005A, 1'b0, 32'h100, 4'b0010, 32'h0000_5A00};
        vecs[7] = '{2'd1, 32'h206, 32'h0000_BEEF, 1'b0, 32'h204, 4'b1100, 32'hBEEF_0000};
        vecs[8] = '{2'd3, 32'h400, 32'h0000_0001, 1'b1, 32'h0,   4'b0000, 32'h0};
        vecs[9] = '{2'd0, 32'h102, 32'hFFFF_FF3C, 1'b0, 32'h100, 4'b0100, 32'h003C_0000};

        resetn = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        ldValid = 0; ldAddr = 0;
        wEnqValid = 0; wEnqKill = 0; wEnqAddr = 0; wEnqSize = 0; wEnqData = 0;
        wDeqReady = 0; wLdValid = 0; wLdAddr = 0;

        // Reset state of both instances.
        @(negedge clk);
        checkOutput("rst_deq_valid", deqValid, 0);
        checkOutput("rst_empty", emptyS, 1);
        checkOutput("rst_full", fullS, 0);
        checkOutput("rst64_empty", wEmpty, 1);
        resetn = 1'b1;
        nextCycle();

        // Table: each store goes into an empty buffer, is inspected at the
        // head, then drained.
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(1, 0, vecs[i].size, vecs[i].addr, vecs[i].data, 0);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_err", i), excErr, vecs[i].expErr);
            nextCycle();
            applyStimulus(0, 0, 0, 0, 0, 0);
            @(negedge clk);
            if (vecs[i].expErr) begin
                checkOutput($sformatf("vec%0d_err_empty", i), emptyS, 1);
            end else begin
                checkOutput($sformatf("vec%0d_valid", i), deqValid, 1);
                checkOutput($sformatf("vec%0d_addr", i), deqAddr, vecs[i].expAddr);
                checkOutput($sformatf("vec%0d_strb", i), deqWstrb, vecs[i].expStrb);
                checkOutput($sformatf("vec%0d_data", i), deqData & laneMask32(vecs[i].expStrb), vecs[i].expData);
            end
            applyStimulus(0, 0, 0, 0, 0, 1);
            nextCycle();
            applyStimulus(0, 0, 0, 0, 0, 0);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_drained", i), emptyS, 1);
            nextCycle();
        end

        // Two byte stores to one word merge into a single entry.
        applyStimulus(1, 0, 2'd0, 32'h300, 32'h11, 0);
        nextCycle();
        applyStimulus(1, 0, 2'd0, 32'h301, 32'h22, 0);
        @(negedge clk);
        checkOutput("merge_ready", enqReady, 1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("merge_addr", deqAddr, 32'h300);
        checkOutput("merge_strb", deqWstrb, 4'b0011);
        checkOutput("merge_data", deqData & 32'h0000_FFFF, 32'h0000_2211);
        applyStimulus(0, 0, 0, 0, 0, 1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("merge_single_entry", emptyS, 1);
        nextCycle();

        // Fill to capacity, probe enq_ready, then dequeue and enqueue together.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 2'd2, 32'h500 + 32'(4 * i), 32'hA0 + 32'(i), 0);
            nextCycle();
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("fill_full", fullS, 1);
        checkOutput("fill_not_empty", emptyS, 0);
        applyStimulus(1, 1, 2'd2, 32'h510, 32'h0, 0);
        #1 checkOutput("full_new_addr_ready", enqReady, 0);
        applyStimulus(1, 1, 2'd0, 32'h50D, 32'h0, 0);
        #1 checkOutput("full_tail_addr_ready", enqReady, 1);
        applyStimulus(1, 0, 2'd2, 32'h510, 32'h55, 1);
        #1 checkOutput("full_deq_enq_ready", enqReady, 1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("wrap_still_full", fullS, 1);
        for (int k = 0; k < 4; k++) begin
            word = (k == 3) ? 32'h510 : 32'h504 + 32'(4 * k);
            tmpD = (k == 3) ? 32'h55 : 32'hA1 + 32'(k);
            checkOutput($sformatf("wrap_valid%0d", k), deqValid, 1);
            checkOutput($sformatf("wrap_addr%0d", k), deqAddr, word);
            checkOutput($sformatf("wrap_data%0d", k), deqData, tmpD);
            applyStimulus(0, 0, 0, 0, 0, 1);
            nextCycle();
            applyStimulus(0, 0, 0, 0, 0, 0);
            @(negedge clk);
        end
        checkOutput("wrap_drained", emptyS, 1);
        nextCycle();

        // 64-bit path: aligned doubleword, misaligned doubleword, and a
        // word store to the leaving single entry that must allocate.
        wEnqValid = 1; wEnqSize = 2'd3; wEnqAddr = 32'h408; wEnqData = 64'h1122_3344_5566_7788;
        @(negedge clk);
        checkOutput("sd_err", wExcErr, 0);
        nextCycle();
        wEnqValid = 0;
        @(negedge clk);
        checkOutput("sd_addr", wDeqAddr, 32'h408);
        checkOutput("sd_strb", wDeqWstrb, 8'hFF);
        checkOutput("sd_data", wDeqData, 64'h1122_3344_5566_7788);
        wEnqValid = 1; wEnqSize = 2'd3; wEnqAddr = 32'h404;
        #1 checkOutput("sd_mis_err", wExcErr, 1);
        wEnqSize = 2'd2; wEnqAddr = 32'h40C; wEnqData = 64'hCAFE_F00D; wDeqReady = 1;
        #1 checkOutput("sw64_ready", wEnqReady, 1);
        nextCycle();
        wEnqValid = 0; wDeqReady = 0;
        @(negedge clk);
        checkOutput("sw64_alloc_valid", wDeqValid, 1);
        checkOutput("sw64_strb", wDeqWstrb, 8'hF0);
        checkOutput("sw64_data", wDeqData & 64'hFFFF_FFFF_0000_0000, 64'hCAFE_F00D_0000_0000);
        wDeqReady = 1;
        nextCycle();
        wDeqReady = 0;
        @(negedge clk);
        checkOutput("sw64_drained", wEmpty, 1);
        nextCycle();

        // A killed store leaves no trace.
        applyStimulus(1, 1, 2'd2, 32'h600, 32'h1, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("kill_empty", emptyS, 1);
        checkOutput("kill_deq_valid", deqValid, 0);
        nextCycle();

        // Load hazards, including invisibility of the entry being written.
        applyStimulus(1, 0, 2'd0, 32'h100, 32'h77, 0);
        ldValid = 1; ldAddr = 32'h101;
        @(negedge clk);
        checkOutput("hz_same_cycle", ldHazard, 0);
        nextCycle();
        applyStimulus(1, 0, 2'd2, 32'h104, 32'h88, 0);
        @(negedge clk);
        checkOutput("hz_buffered", ldHazard, 1);
        ldAddr = 32'h104;
        #1 checkOutput("hz_writing", ldHazard, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("hz_second", ldHazard, 1);
        ldValid = 0;
        #1 checkOutput("hz_no_valid", ldHazard, 0);

        // Reset while draining drops everything at once.
        applyStimulus(0, 0, 0, 0, 0, 1);
        nextCycle();
        @(negedge clk);
        checkOutput("drain_head", deqAddr, 32'h104);
        resetn = 1'b0;
        #1;
        checkOutput("rst_mid_deq_valid", deqValid, 0);
        checkOutput("rst_mid_empty", emptyS, 1);
        nextCycle();
        @(negedge clk);
        resetn = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0);
        nextCycle();
        @(negedge clk);
        checkOutput("rst_dropped", emptyS, 1);
        nextCycle();

        // Random traffic against a queue of buffered words.
        q.delete();
        for (int n = 0; n < 400; n++) begin
            rSize = 2'($urandom_range(0, 3));
            rAddr = 32'h100 + $urandom_range(0, 15);
            rData = $urandom;
            rV    = ($urandom_range(0, 3) != 0);
            rKill = ($urandom_range(0, 7) == 0);
            rDr   = 1'($urandom_range(0, 1));
            ldValid = 1'($urandom_range(0, 1));
            ldAddr  = 32'h100 + $urandom_range(0, 15);
            applyStimulus(rV, rKill, rSize, rAddr, rData, rDr);
            @(negedge clk);

            expValid = (q.size() != 0);
            deqF     = expValid && rDr;
            mergeOk  = (q.size() != 0) && (q[q.size()-1].addr == (rAddr & ~32'h3))
                       && !(deqF && q.size() == 1);
            expReady = mergeOk || (q.size() < 4) || deqF;
            expErr   = rV && modelErr(rSize, rAddr, 32);
            hz = 1'b0;
            foreach (q[j]) if (ldValid && q[j].addr == (ldAddr & ~32'h3)) hz = 1'b1;

            checkOutput("rnd_deq_valid", deqValid, expValid);
            if (expValid) begin
                checkOutput("rnd_deq_addr", deqAddr, q[0].addr);
                checkOutput("rnd_deq_strb", deqWstrb, q[0].strb);
                checkOutput("rnd_deq_data", deqData & laneMask32(q[0].strb), q[0].data & laneMask32(q[0].strb));
            end
            checkOutput("rnd_full", fullS, q.size() == 4);
            checkOutput("rnd_empty", emptyS, q.size() == 0);
            checkOutput("rnd_enq_ready", enqReady, expReady);
            checkOutput("rnd_err", excErr, expErr);
            checkOutput("rnd_hazard", ldHazard, hz);

            fire    = rV && expReady && !rKill && !expErr;
            off     = int'(rAddr % 4);
            strbInt = ((1 << (1 << rSize)) - 1) << off;
            stStrb  = 4'(strbInt);
            stData  = rData << (8 * off);
            if (deqF) void'(q.pop_front());
            if (fire) begin
                if (mergeOk) begin
                    tmp = q[q.size()-1];
                    for (int b = 0; b < 4; b++) begin
                        if (stStrb[b]) tmp.data[8*b +: 8] = stData[8*b +: 8];
                    end
                    tmp.strb = tmp.strb | stStrb;
                    q[q.size()-1] = tmp;
                end else begin
                    tmp.addr = rAddr & ~32'h3;
                    tmp.data = stData;
                    tmp.strb = stStrb;
                    q.push_back(tmp);
                end
            end
            nextCycle();
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        ldValid = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
